// File: rtl/leading_zero_counter.sv
// leading_zero_counter: registered priority encoder with an all-zero flag.
// MODE 0 reports the index of the lowest set bit (trailing zeros); MODE 1
// reports (WIDTH-1) minus the index of the highest set bit (leading zeros).
// Optional simulation checks are compiled in when LZC_ASSERTS_EN is defined.
module leading_zero_counter #(
  parameter int WIDTH     = 2,
  parameter bit MODE      = 1'b0,
  parameter int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Tree depth equals the count width; WIDTH == 1 still gets one level with a
  // single padded leaf so the structure stays uniform.
  localparam int LEVELS = CNT_WIDTH;
  localparam int P2     = 1 << LEVELS;

  logic [P2-1:0]        scan;
  logic [P2-1:0]        vld [LEVELS+1];
  logic [CNT_WIDTH-1:0] idx [LEVELS+1][P2];
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 empty_d;

  // Bit order presented to the tree; leading-zero mode mirrors the input so
  // the winning tree index is already the leading-zero count. Padding is zero.
  always_comb begin
    scan = '0;
    for (int i = 0; i < WIDTH; i++) begin
      scan[i] = MODE ? in_i[WIDTH-1-i] : in_i[i];
    end
  end

  // Binary reduction: each node prefers its lower-index child when that child
  // holds a set bit, otherwise takes the upper child and sets this level's bit.
  always_comb begin
    for (int l = 0; l <= LEVELS; l++) begin
      vld[l] = '0;
      for (int j = 0; j < P2; j++) begin
        idx[l][j] = '0;
      end
    end
    vld[0] = scan;
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = 0; j < (P2 >> (l + 1)); j++) begin
        vld[l+1][j] = vld[l][2*j] | vld[l][2*j+1];
        if (vld[l][2*j]) begin
          idx[l+1][j] = idx[l][2*j];
        end else begin
          idx[l+1][j] = idx[l][2*j+1] | (CNT_WIDTH'(1) << l);
        end
      end
    end
  end

  // An empty root would otherwise report all-ones; force the count to zero.
  always_comb begin
    empty_d = ~vld[LEVELS][0];
    cnt_d   = empty_d ? '0 : idx[LEVELS][0];
  end

  // Single output register stage; reset presents an empty result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o   <= '0;
      empty_o <= 1'b1;
    end else begin
      cnt_o   <= cnt_d;
      empty_o <= empty_d;
    end
  end

`ifdef LZC_ASSERTS_EN
  if (WIDTH < 1) begin : g_width_chk
    $fatal(1, "leading_zero_counter: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] in_q;
  logic             armed_q;

  // Copy of the input behind the current output, and a flag that the current
  // output came from a non-reset edge.
  always_ff @(posedge clk_i) begin
    in_q    <= in_i;
    armed_q <= ~rst_i;
  end

  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
    armed_q |-> (int'(cnt_o) < WIDTH))
    else $fatal(1, "leading_zero_counter: count out of range");

  a_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    armed_q |-> (empty_o == (in_q == '0)))
    else $fatal(1, "leading_zero_counter: empty flag wrong");

  a_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    (armed_q && !empty_o && (int'(cnt_o) < WIDTH)) |->
      in_q[MODE ? (WIDTH - 1 - int'(cnt_o)) : int'(cnt_o)])
    else $fatal(1, "leading_zero_counter: reported bit not set");
`endif

endmodule

// File: tb/tb_leading_zero_counter.sv
// Scoreboard bench for leading_zero_counter: five instances (W8/W5 in both
// modes, W1) share one stimulus table of directed vectors with hand-computed
// expectations; a monitor pops and compares one entry per cycle.
module tb_leading_zero_counter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] in8   = '0;
  logic [4:0] in5   = '0;
  logic [0:0] in1   = '0;

  logic [2:0] c8m0, c8m1, c5m0, c5m1;
  logic [0:0] c1;
  logic       e8m0, e8m1, e5m0, e5m1, e1;

  always #5 clk_i = ~clk_i;

  leading_zero_counter #(.WIDTH(8), .MODE(1'b0)) u_w8m0 (
    .clk_i(clk_i), .rst_i(rst_i), .in_i(in8), .cnt_o(c8m0), .empty_o(e8m0));
  leading_zero_counter #(.WIDTH(8), .MODE(1'b1)) u_w8m1 (
    .clk_i(clk_i), .rst_i(rst_i), .in_i(in8), .cnt_o(c8m1), .empty_o(e8m1));
  leading_zero_counter #(.WIDTH(5), .MODE(1'b0)) u_w5m0 (
    .clk_i(clk_i), .rst_i(rst_i), .in_i(in5), .cnt_o(c5m0), .empty_o(e5m0));
  leading_zero_counter #(.WIDTH(5), .MODE(1'b1)) u_w5m1 (
    .clk_i(clk_i), .rst_i(rst_i), .in_i(in5), .cnt_o(c5m1), .empty_o(e5m1));
  leading_zero_counter #(.WIDTH(1), .MODE(1'b0)) u_w1 (
    .clk_i(clk_i), .rst_i(rst_i), .in_i(in1), .cnt_o(c1), .empty_o(e1));

  typedef struct packed {
    logic       rst;
    logic [7:0] i8;
    logic [4:0] i5;
    logic       i1;
    logic [2:0] x8m0;
    logic [2:0] x8m1;
    logic       x8e;
    logic [2:0] x5m0;
    logic [2:0] x5m1;
    logic       x5e;
    logic       x1c;
    logic       x1e;
  } vec_t;

  vec_t vecs [$];
  vec_t sb_q [$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_seen  = 0;

  task automatic check(input string name, input int step, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
  endtask

  // Monitor: one result per cycle, sampled just after the rising edge.
  always @(posedge clk_i) begin
    #1;
    if (sb_q.size() > 0) begin
      vec_t e;
      e = sb_q.pop_front();
      check("w8m0_cnt",   n_seen, int'(c8m0), int'(e.x8m0));
      check("w8m0_empty", n_seen, int'(e8m0), int'(e.x8e));
      check("w8m1_cnt",   n_seen, int'(c8m1), int'(e.x8m1));
      check("w8m1_empty", n_seen, int'(e8m1), int'(e.x8e));
      check("w5m0_cnt",   n_seen, int'(c5m0), int'(e.x5m0));
      check("w5m0_empty", n_seen, int'(e5m0), int'(e.x5e));
      check("w5m1_cnt",   n_seen, int'(c5m1), int'(e.x5m1));
      check("w5m1_empty", n_seen, int'(e5m1), int'(e.x5e));
      check("w1_cnt",     n_seen, int'(c1),   int'(e.x1c));
      check("w1_empty",   n_seen, int'(e1),   int'(e.x1e));
      n_seen++;
    end
  end

  initial begin
    //              rst  in8           in5       in1   8m0   8m1   8e    5m0   5m1   5e    1c    1e
    vecs.push_back({1'b1, 8'h28,       5'b10000, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back({1'b0, 8'b00101000, 5'b10000, 1'b1, 3'd3, 3'd2, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 8'h80,       5'b00001, 1'b0, 3'd7, 3'd0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 8'h01,       5'b00000, 1'b1, 3'd0, 3'd7, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0});
    vecs.push_back({1'b0, 8'hFF,       5'b01100, 1'b0, 3'd0, 3'd0, 1'b0, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 8'h00,       5'b11111, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 8'h10,       5'b00110, 1'b1, 3'd4, 3'd3, 1'b0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 8'h04,       5'b01000, 1'b0, 3'd2, 3'd5, 1'b0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b1, 8'h04,       5'b01000, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back({1'b0, 8'h04,       5'b00010, 1'b0, 3'd2, 3'd5, 1'b0, 3'd1, 3'd3, 1'b0, 1'b0, 1'b1});
    vecs.push_back({1'b0, 8'h06,       5'b10001, 1'b1, 3'd1, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 8'h40,       5'b00100, 1'b1, 3'd6, 3'd1, 1'b0, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0});
    vecs.push_back({1'b0, 8'h00,       5'b00000, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1});

    foreach (vecs[k]) begin
      @(negedge clk_i);
      rst_i = vecs[k].rst;
      in8   = vecs[k].i8;
      in5   = vecs[k].i5;
      in1   = vecs[k].i1;
      sb_q.push_back(vecs[k]);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    check("results_drained", 0, sb_q.size(), 0);
    check("results_seen", 0, n_seen, vecs.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/leading_zero_counter.md
# leading_zero_counter

Registered leading/trailing zero counter for one-hot and priority-select logic. It reports the position of the first set bit of an input vector, counting from the LSB (trailing-zero mode) or from the MSB (leading-zero mode). It also flags an all-zero input. The fair round-robin arbiter uses it to locate the next requester above or below the current priority index, and it is reusable anywhere a priority encoder with an empty flag is needed.

## Interface
- Clocking/reset (already decided): one clock, `clk_i`; reset `rst_i` is synchronous and active-high.
- Parameters:
  - `WIDTH`, default 2: input vector width; must be ≥ 1.
  - `MODE`, default 1'b0: 0 = count trailing zeros (scan from bit 0 upward); 1 = count leading zeros (scan from bit WIDTH-1 downward).
  - `CNT_WIDTH`, default `$clog2(WIDTH)`, forced to 1 when WIDTH == 1: derived width of the count; do not override.
- Ports:
  - `clk_i`  input  1  clock, rising edge.
  - `rst_i`  input  1  synchronous active-high reset.
  - `in_i`  input  WIDTH  vector to scan.
  - `cnt_o`  output  CNT_WIDTH  zero count (registered).
  - `empty_o`  output  1  high when the sampled `in_i` was all zeros (registered).

## Operation
- MODE 0: `cnt_o` = index of the lowest set bit of `in_i`.
- MODE 1: `cnt_o` = (WIDTH-1) − index of the highest set bit of `in_i`.
- All-zero input: `empty_o` = 1 and `cnt_o` = 0.
- Any non-zero input: `empty_o` = 0 and `cnt_o` lies in the range 0..WIDTH-1.
- Structure:
  - Binary reduction tree of depth `$clog2(WIDTH)`, padded to the next power of two.
  - Padded leaves carry no request and contribute no index.
  - At each node, select the left (lower-index after MODE reversal) child if it has any set bit, else the right child.
  - For MODE 1, reverse `in_i` before the tree. The tree index is then directly the leading-zero count.
- Width rules:
  - Non-power-of-two WIDTH must never produce a count ≥ WIDTH.
  - WIDTH == 1: `cnt_o` is always 0 and `empty_o` = ~in_i[0].
- No other state exists; the block is a pure function plus one output register stage.

## Timing
- Latency is 1 cycle: the outputs after rising edge N reflect `in_i` sampled at edge N.
- Outputs update every cycle. There is no handshake and no enable.
- Reset:
  - With `rst_i` = 1 at an edge, the next outputs are `cnt_o` = 0 and `empty_o` = 1.
  - Reset dominates any `in_i` value.
  - Asserting reset mid-stream discards the pending result. The first valid result appears one cycle after the first edge with `rst_i` = 0.
- Before the first reset edge, output values are undefined.
- `in_i` must be stable around the rising edge. Glitches between edges are invisible.

## Configuration
- `LZC_ASSERTS_EN` defined:
  - Simulation-only checks are compiled in. They are ignored by synthesis and disabled while `rst_i` = 1.
  - Elaboration check: WIDTH ≥ 1.
  - Every cycle: `cnt_o` < WIDTH.
  - Every cycle: `empty_o` equals (`$past(in_i)` == 0).
  - When not empty, the bit at the reported position of the previous `in_i` is 1 (position = cnt for MODE 0, WIDTH-1-cnt for MODE 1).
  - Violations call `$fatal`.
- Undefined: no checks are present. The RTL function is identical either way.

## Test plan
- WIDTH=8, MODE=0, `in_i`=8'b0010_1000 -> next cycle `cnt_o`=3, `empty_o`=0. Then `in_i`=8'h80 -> `cnt_o`=7.
- WIDTH=8, MODE=1, `in_i`=8'b0010_1000 -> `cnt_o`=2. Then `in_i`=8'h01 -> `cnt_o`=7. Then `in_i`=8'hFF -> `cnt_o`=0.
- WIDTH=8, either MODE, `in_i`=0 -> `cnt_o`=0, `empty_o`=1. Then `in_i`=8'h10 -> `empty_o`=0 the following cycle only.
- WIDTH=5, MODE=0, `in_i`=5'b10000 -> `cnt_o`=4. MODE=1 with the same input -> `cnt_o`=0. MODE=1 with `in_i`=5'b00001 -> `cnt_o`=4.
- Reset mid-stream: `in_i`=8'h04 streaming, `rst_i`=1 for one edge -> `cnt_o`=0 and `empty_o`=1 that cycle. Next edge with `rst_i`=0 -> `cnt_o`=2 (MODE 0).
- WIDTH=1: `in_i`=1 -> `cnt_o`=0, `empty_o`=0. `in_i`=0 -> `cnt_o`=0, `empty_o`=1.
